// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
//   func_t  : bus function codes presented on func[2:0]
//   state_t : controller states
//   STAT_*  : bit positions inside the status word returned by RD_STAT
package seq_mult_pkg;

   typedef enum logic [2:0] {
      LOAD_A  = 3'b000,
      LOAD_B  = 3'b001,
      RD_LO   = 3'b010,
      RD_HI   = 3'b011,
      RD_STAT = 3'b100,
      IDLE_F  = 3'b111
   } func_t;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   localparam int STAT_READY_BIT = 0;
   localparam int STAT_VALID_BIT = 1;

   function automatic logic is_read_code(input logic [2:0] f);
      return (f == RD_LO) || (f == RD_HI) || (f == RD_STAT);
   endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand registers, working multiplicand, (N+1)-bit adder, product shift
// register and step down-counter.
// Ports:
//   clock, reset  : clock, async active-high reset
//   load_a/load_b : capture din into operand A / B
//   din           : bus data in
//   init          : begin a multiply (copies A to multiplicand, B to P_lo)
//   step          : perform one add/shift step
//   sgn_in        : two's-complement mode, captured with init
//   p_hi, p_lo    : product halves
//   last          : current step is the final one (count == 1)
module seq_mult_datapath
   import seq_mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load_a,
   input  logic         load_b,
   input  logic [N-1:0] din,
   input  logic         init,
   input  logic         step,
   input  logic         sgn_in,
   output logic [N-1:0] p_hi,
   output logic [N-1:0] p_lo,
   output logic         last
);

   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic [N-1:0]  m_q;
   logic          sgn_q;
   logic [CW-1:0] count;
   logic [N:0]    hi_ext;
   logic [N:0]    m_ext;
   logic [N:0]    sum;

   assign last = (count == CW'(1));

   // In signed mode both addends are sign-extended so sum[N] is the true
   // sign and becomes the new MSB on the right shift (arithmetic shift).
   // In unsigned mode sum[N] is simply the carry out.
   always_comb begin
      hi_ext = {sgn_q & p_hi[N-1], p_hi};
      m_ext  = {sgn_q & m_q[N-1], m_q};
      sum    = hi_ext;
      if (p_lo[0]) begin
         // On the final step p_lo[0] holds the multiplier MSB, whose weight
         // is negative in two's complement.
         if (sgn_q && last) begin
            sum = hi_ext - m_ext;
         end else begin
            sum = hi_ext + m_ext;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         m_q   <= '0;
         sgn_q <= 1'b0;
         p_hi  <= '0;
         p_lo  <= '0;
         count <= '0;
      end else begin
         if (load_a) a_q <= din;
         if (load_b) b_q <= din;
         // init reads the pre-load operand values, so a load on the same
         // edge only affects the next multiply. A is copied into m_q so a
         // same-edge load of A cannot leak into the running multiply.
         if (init) begin
            m_q   <= a_q;
            sgn_q <= sgn_in;
            p_hi  <= '0;
            p_lo  <= b_q;
            count <= CW'(N);
         end else if (step) begin
            p_hi  <= sum[N:1];
            p_lo  <= {sum[0], p_lo[N-1:1]};
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/seq_multiplier_bus.sv
// Sequential shift-add multiplier on a shared bidirectional bus.
// Host loads A and B over the bus, pulses start, waits for ready, then reads
// the 2N-bit product as low/high halves plus a {valid, ready} status word.
// Optional feature macro: SEQ_MULT_SIGNED_EN adds the signed_op port for
// two's-complement operands (sampled with start).
// Ports:
//   clock     : system clock, rising edge
//   reset     : async active-high reset
//   start     : begin multiply (ignored while computing)
//   func[2:0] : bus function code (see seq_mult_pkg::func_t)
//   oe        : output enable for read codes
//   data[N-1:0] : shared bus, high-Z unless driving a read word
//   ready     : 1 = idle, 0 = computing
//   signed_op : (SEQ_MULT_SIGNED_EN only) 1 = signed operands
//
// state | meaning
// IDLE  | waiting for loads/start; ready=1
// CALC  | one add/shift step per edge, N steps total; ready=0
module seq_multiplier_bus
   import seq_mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [2:0]   func,
   input  logic         oe,
   inout  wire  [N-1:0] data,
   output logic         ready
`ifdef SEQ_MULT_SIGNED_EN
   ,
   input  logic         signed_op
`endif
);

   state_t       state;
   state_t       state_nx;
   logic         valid;
   logic         init;
   logic         step;
   logic         last;
   logic         load_a;
   logic         load_b;
   logic         sgn;
   logic         drive;
   logic [N-1:0] p_hi;
   logic [N-1:0] p_lo;
   logic [N-1:0] rd_word;

`ifdef SEQ_MULT_SIGNED_EN
   assign sgn = signed_op;
`else
   assign sgn = 1'b0;
`endif

   // Operand loads are only honoured while idle.
   assign load_a = (state == IDLE) && (func == LOAD_A);
   assign load_b = (state == IDLE) && (func == LOAD_B);
   assign ready  = (state == IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      init     = 1'b0;
      step     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               init     = 1'b1;
               state_nx = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
      end else if (init || load_a || load_b) begin
         valid <= 1'b0;
      end else if (step && last) begin
         valid <= 1'b1;
      end
   end

   seq_mult_datapath #(.N(N)) u_datapath (
      .clock  (clock),
      .reset  (reset),
      .load_a (load_a),
      .load_b (load_b),
      .din    (data),
      .init   (init),
      .step   (step),
      .sgn_in (sgn),
      .p_hi   (p_hi),
      .p_lo   (p_lo),
      .last   (last)
   );

   always_comb begin
      rd_word = '0;
      case (func)
         RD_LO:   rd_word = p_lo;
         RD_HI:   rd_word = p_hi;
         RD_STAT: begin
            rd_word[STAT_READY_BIT] = ready;
            rd_word[STAT_VALID_BIT] = valid;
         end
         default: rd_word = '0;
      endcase
   end

   // Reads during CALC still drive the bus; the value is the partial product.
   assign drive = oe && is_read_code(func);
   assign data  = drive ? rd_word : 'z;

endmodule

// File: tb/tb_seq_multiplier_bus.sv
module tb_seq_multiplier_bus;

   localparam int N = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] func;
   logic       oe;
   logic       ready;
   logic [7:0] tb_val;
   logic       tb_en;
   wire  [7:0] data;
`ifdef SEQ_MULT_SIGNED_EN
   logic       sop;
`endif

   assign data = tb_en ? tb_val : 'z;

   seq_multiplier_bus #(.N(N)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .func  (func),
      .oe    (oe),
      .data  (data),
      .ready (ready)
`ifdef SEQ_MULT_SIGNED_EN
      ,
      .signed_op (sop)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   string      qn[$];
   logic [7:0] qv[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: whenever the DUT is presenting a read word, pop and compare.
   initial begin
      string      nm;
      logic [7:0] ev;
      forever begin
         @(negedge clock);
         if (oe && (func == 3'b010 || func == 3'b011 || func == 3'b100)) begin
            if (qv.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read: got 0x%0h expected no read", data);
            end else begin
               nm = qn.pop_front();
               ev = qv.pop_front();
               chk(nm, {8'h00, data}, {8'h00, ev});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [2:0] f, input logic [7:0] v);
      func   = f;
      tb_en  = 1'b1;
      tb_val = v;
      cyc();
      func   = 3'b111;
      tb_en  = 1'b0;
   endtask

   task automatic rd(input logic [2:0] f, input logic [7:0] exp, input string nm);
      func = f;
      oe   = 1'b1;
      qn.push_back(nm);
      qv.push_back(exp);
      cyc();
      oe   = 1'b0;
      func = 3'b111;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 40) begin
         cyc();
         n++;
      end
   endtask

   task automatic run_and_read(input logic [15:0] p, input string nm);
      int n;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk({nm, " ready_low"}, {15'd0, ready}, 16'd0);
      wait_ready(n);
      chk({nm, " latency"}, n[15:0], 16'd8);
      rd(3'b010, p[7:0], {nm, " lo"});
      rd(3'b011, p[15:8], {nm, " hi"});
      rd(3'b100, 8'h03, {nm, " stat"});
   endtask

   task automatic mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                      input string nm);
      load(3'b000, a);
      load(3'b001, b);
      rd(3'b100, 8'h01, {nm, " stat_after_load"});
      run_and_read(p, nm);
   endtask

   initial begin
      int n;
      reset  = 1'b1;
      start  = 1'b0;
      func   = 3'b111;
      oe     = 1'b0;
      tb_en  = 1'b0;
      tb_val = 8'h00;
`ifdef SEQ_MULT_SIGNED_EN
      sop    = 1'b0;
`endif
      #12;
      chk("ready_in_reset", {15'd0, ready}, 16'd1);
      cyc();
      reset = 1'b0;
      cyc();
      rd(3'b100, 8'h01, "reset stat");
      rd(3'b010, 8'h00, "reset lo");
      rd(3'b011, 8'h00, "reset hi");

      mul(8'd123, 8'd234, 16'h706E, "m123x234");
      mul(8'h55, 8'hAA, 16'h3872, "m55xAA");
      mul(8'hFF, 8'hFF, 16'hFE01, "mFFxFF");
      mul(8'h00, 8'h9C, 16'h0000, "m00x9C");
      mul(8'hFD, 8'h05, 16'h04F1, "uFDx05");
      mul(8'h80, 8'h80, 16'h4000, "u80x80");

      // Busy guards: load A and a second start during CALC are ignored.
      load(3'b000, 8'h55);
      load(3'b001, 8'h03);
      start = 1'b1;
      cyc();
      start = 1'b0;
      n = 0;
      while (!ready && n < 40) begin
         if (n == 2) begin
            func   = 3'b000;
            tb_en  = 1'b1;
            tb_val = 8'h11;
         end
         if (n == 3) start = 1'b1;
         cyc();
         func  = 3'b111;
         tb_en = 1'b0;
         start = 1'b0;
         n++;
      end
      chk("busy latency", n[15:0], 16'd8);
      rd(3'b010, 8'hFF, "busy lo");
      rd(3'b011, 8'h00, "busy hi");
      rd(3'b100, 8'h03, "busy stat");
      run_and_read(16'h00FF, "busy A_kept");

      // Start and load A on the same edge: multiply uses the old A.
      load(3'b000, 8'h02);
      load(3'b001, 8'h03);
      func   = 3'b000;
      tb_en  = 1'b1;
      tb_val = 8'h07;
      start  = 1'b1;
      cyc();
      func   = 3'b111;
      tb_en  = 1'b0;
      start  = 1'b0;
      wait_ready(n);
      chk("same_edge latency", n[15:0], 16'd8);
      rd(3'b010, 8'h06, "same_edge lo");
      rd(3'b011, 8'h00, "same_edge hi");
      run_and_read(16'h0015, "same_edge new_A");

      // Reset in the 4th CALC cycle aborts and clears everything.
      load(3'b000, 8'h0F);
      load(3'b001, 8'h0F);
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("pre_reset ready", {15'd0, ready}, 16'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset ready", {15'd0, ready}, 16'd1);
      cyc();
      reset = 1'b0;
      rd(3'b100, 8'h01, "abort stat");
      rd(3'b010, 8'h00, "abort lo");
      rd(3'b011, 8'h00, "abort hi");

      // Bus release: bench drives freely on non-read codes with oe=1.
      oe     = 1'b1;
      tb_en  = 1'b1;
      func   = 3'b000;
      tb_val = 8'hA5;
      #1;
      chk("release f000", {7'd0, $isunknown(data), data}, {8'h00, 8'hA5});
      cyc();
      func   = 3'b111;
      tb_val = 8'h3C;
      #1;
      chk("release f111", {7'd0, $isunknown(data), data}, {8'h00, 8'h3C});
      func   = 3'b101;
      tb_val = 8'hC3;
      #1;
      chk("release f101", {7'd0, $isunknown(data), data}, {8'h00, 8'hC3});
      cyc();
      oe    = 1'b0;
      tb_en = 1'b0;
      func  = 3'b111;
      load(3'b001, 8'h02);
      run_and_read(16'h014A, "release A_loaded");

`ifdef SEQ_MULT_SIGNED_EN
      sop = 1'b1;
      mul(8'hFD, 8'h05, 16'hFFF1, "sFDx05");
      mul(8'h80, 8'h80, 16'h4000, "s80x80");
      mul(8'h7F, 8'hFF, 16'hFF81, "s7FxFF");
      sop = 1'b0;
      mul(8'h80, 8'h80, 16'h4000, "u2_80x80");
      mul(8'hFD, 8'h05, 16'h04F1, "u2_FDx05");
`endif

      cyc();
      cyc();
      chk("queue drained", qv.size(), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
